// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_hazard_ctrl_pkg;

  localparam int SEL_RF         = 0;
  localparam int PC_REG_DEFAULT = 15;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memtoreg;
    logic pcwrite;
  } rec_flags_t;

  function automatic int sel_width(input int fwd_depth);
    return $clog2(fwd_depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_match.sv
// Compares one in-flight destination record against the D-stage and E-stage source operands.
module pipe_hazard_ctrl_hz_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RADDR_W = 4,
  parameter int NUM_SRC = 2,
  parameter int PC_REG  = PC_REG_DEFAULT
) (
  input  logic                       wr_en,
  input  logic [RADDR_W-1:0]         wa,
  input  logic [NUM_SRC*RADDR_W-1:0] ra_d,
  input  logic [NUM_SRC-1:0]         ra_used_d,
  input  logic [NUM_SRC*RADDR_W-1:0] ra_e,
  input  logic [NUM_SRC-1:0]         ra_used_e,
  output logic [NUM_SRC-1:0]         match_d,
  output logic [NUM_SRC-1:0]         match_e
);

  localparam logic [RADDR_W-1:0] PC_ADDR = RADDR_W'(PC_REG);

  // The PC is read through its own path, so it never takes part in forwarding or stalls.
  always_comb begin
    match_d = '0;
    match_e = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      match_d[i] = wr_en & ra_used_d[i]
                 & (ra_d[i*RADDR_W +: RADDR_W] == wa)
                 & (ra_d[i*RADDR_W +: RADDR_W] != PC_ADDR);
      match_e[i] = wr_en & ra_used_e[i]
                 & (ra_e[i*RADDR_W +: RADDR_W] == wa)
                 & (ra_e[i*RADDR_W +: RADDR_W] != PC_ADDR);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight destinations and drives stall, flush and forward selects.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int  RADDR_W   = 4,
  parameter int  NUM_SRC   = 2,
  parameter int  FWD_DEPTH = 2,
  parameter int  PC_REG    = PC_REG_DEFAULT,
  localparam int SELW      = sel_width(FWD_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*RADDR_W-1:0] ra_d,
  input  logic [NUM_SRC-1:0]         ra_used_d,
  input  logic                       valid_d,
  input  logic [RADDR_W-1:0]         wa_d,
  input  logic                       regwrite_d,
  input  logic                       memtoreg_d,
  input  logic                       pcwrite_d,
  input  logic                       branch_taken_e,
  input  logic                       ext_stall,
  output logic                       stall_f,
  output logic                       stall_d,
  output logic                       flush_d,
  output logic                       flush_e,
  output logic                       stall_em,
  output logic [NUM_SRC*SELW-1:0]    fwd_sel_e
);

  localparam int NREC = FWD_DEPTH + 1;

  // Index 0 is the E stage, 1..FWD_DEPTH are M..W.
  rec_flags_t                 flags_q [NREC];
  logic [RADDR_W-1:0]         wa_q    [NREC];
  logic [NUM_SRC*RADDR_W-1:0] ra_e_q;
  logic [NUM_SRC-1:0]         ra_used_e_q;

  logic [NUM_SRC-1:0]         match_d [NREC];
  logic [NUM_SRC-1:0]         match_e [NREC];
  logic [NUM_SRC*SELW-1:0]    fwd_sel_c;
  logic                       ldstall;
  logic                       pcpend;
  logic                       pcdone;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NREC; k++) begin
        flags_q[k] <= '0;
        wa_q[k]    <= '0;
      end
      ra_e_q      <= '0;
      ra_used_e_q <= '0;
    end else if (!ext_stall) begin
      for (int k = 1; k < NREC; k++) begin
        flags_q[k] <= flags_q[k-1];
        wa_q[k]    <= wa_q[k-1];
      end
      if (flush_e) begin
        flags_q[0]  <= '0;
        wa_q[0]     <= '0;
        ra_e_q      <= '0;
        ra_used_e_q <= '0;
      end else begin
        flags_q[0]  <= '{valid: valid_d, regwrite: regwrite_d,
                         memtoreg: memtoreg_d, pcwrite: pcwrite_d};
        wa_q[0]     <= wa_d;
        ra_e_q      <= ra_d;
        ra_used_e_q <= ra_used_d;
      end
    end
  end

  for (genvar k = 0; k < NREC; k++) begin : g_match
    pipe_hazard_ctrl_hz_match #(
      .RADDR_W (RADDR_W),
      .NUM_SRC (NUM_SRC),
      .PC_REG  (PC_REG)
    ) u_match (
      .wr_en     (flags_q[k].valid & flags_q[k].regwrite),
      .wa        (wa_q[k]),
      .ra_d      (ra_d),
      .ra_used_d (ra_used_d),
      .ra_e      (ra_e_q),
      .ra_used_e (ra_used_e_q),
      .match_d   (match_d[k]),
      .match_e   (match_e[k])
    );
  end

  // Scan oldest to youngest so the youngest eligible producer wins.
  always_comb begin
    fwd_sel_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel_c[i*SELW +: SELW] = SELW'(SEL_RF);
      for (int k = FWD_DEPTH; k >= 0; k--) begin
        if (k != 0 && match_e[k][i] && !(flags_q[k].memtoreg && k < FWD_DEPTH))
          fwd_sel_c[i*SELW +: SELW] = SELW'(k);
      end
    end
  end

  always_comb begin
    ldstall = 1'b0;
    pcpend  = pcwrite_d & valid_d;
    pcdone  = flags_q[FWD_DEPTH].valid & flags_q[FWD_DEPTH].pcwrite;
    for (int k = 0; k < NREC; k++) begin
      if (k + 2 <= FWD_DEPTH && flags_q[k].memtoreg && (|match_d[k]))
        ldstall = 1'b1;
      if (k < FWD_DEPTH && flags_q[k].valid && flags_q[k].pcwrite)
        pcpend = 1'b1;
    end

    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    stall_em  = 1'b0;
    fwd_sel_e = '0;
    if (reset) begin
      fwd_sel_e = fwd_sel_c;
      if (ext_stall) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_em = 1'b1;
      end else if (branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        stall_d = ldstall;
        flush_e = ldstall;
        stall_f = ldstall | pcpend;
        flush_d = pcpend | pcdone;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl at FWD_DEPTH=2 and FWD_DEPTH=3.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic       vd;
    logic [3:0] ra0;
    logic [3:0] ra1;
    logic [1:0] used;
    logic [3:0] wa;
    logic       rw;
    logic       mr;
    logic       pcw;
    logic       br;
    logic       ext;
    logic [4:0] ctl;  // {stall_f, stall_d, flush_d, flush_e, stall_em}
    logic [1:0] s0;
    logic [1:0] s1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [7:0] ra_d2, ra_d3;
  logic [1:0] used_d2, used_d3;
  logic       valid_d2, valid_d3;
  logic [3:0] wa_d2, wa_d3;
  logic       rw_d2, rw_d3, mr_d2, mr_d3, pcw_d2, pcw_d3, br_d2, br_d3, ext_d2, ext_d3;
  logic       sf2, sd2, fd2, fe2, se2;
  logic       sf3, sd3, fd3, fe3, se3;
  logic [3:0] fwd2, fwd3;

  int passed = 0;
  int total  = 0;
  vec_t tab2 [27];
  vec_t tab3 [9];

  pipe_hazard_ctrl #(.RADDR_W(4), .NUM_SRC(2), .FWD_DEPTH(2), .PC_REG(15)) u_d2 (
    .clk(clk), .reset(reset), .ra_d(ra_d2), .ra_used_d(used_d2), .valid_d(valid_d2),
    .wa_d(wa_d2), .regwrite_d(rw_d2), .memtoreg_d(mr_d2), .pcwrite_d(pcw_d2),
    .branch_taken_e(br_d2), .ext_stall(ext_d2), .stall_f(sf2), .stall_d(sd2),
    .flush_d(fd2), .flush_e(fe2), .stall_em(se2), .fwd_sel_e(fwd2));

  pipe_hazard_ctrl #(.RADDR_W(4), .NUM_SRC(2), .FWD_DEPTH(3), .PC_REG(15)) u_d3 (
    .clk(clk), .reset(reset), .ra_d(ra_d3), .ra_used_d(used_d3), .valid_d(valid_d3),
    .wa_d(wa_d3), .regwrite_d(rw_d3), .memtoreg_d(mr_d3), .pcwrite_d(pcw_d3),
    .branch_taken_e(br_d3), .ext_stall(ext_d3), .stall_f(sf3), .stall_d(sd3),
    .flush_d(fd3), .flush_e(fe3), .stall_em(se3), .fwd_sel_e(fwd3));

  function automatic vec_t mk(input int vd, input int ra0, input int ra1, input int used,
                              input int wa, input int rw, input int mr, input int pcw,
                              input int br, input int ext, input int ctl, input int s0,
                              input int s1);
    vec_t v;
    v.vd = vd[0];   v.ra0 = 4'(ra0); v.ra1 = 4'(ra1); v.used = 2'(used);
    v.wa = 4'(wa);  v.rw = rw[0];    v.mr = mr[0];    v.pcw = pcw[0];
    v.br = br[0];   v.ext = ext[0];  v.ctl = 5'(ctl); v.s0 = 2'(s0); v.s1 = 2'(s1);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
  endtask

  task automatic drive2(input vec_t v);
    ra_d2 = {v.ra1, v.ra0}; used_d2 = v.used; valid_d2 = v.vd; wa_d2 = v.wa;
    rw_d2 = v.rw; mr_d2 = v.mr; pcw_d2 = v.pcw; br_d2 = v.br; ext_d2 = v.ext;
  endtask

  task automatic apply(input vec_t v, input bit d3, input int idx);
    if (d3) begin
      ra_d3 = {v.ra1, v.ra0}; used_d3 = v.used; valid_d3 = v.vd; wa_d3 = v.wa;
      rw_d3 = v.rw; mr_d3 = v.mr; pcw_d3 = v.pcw; br_d3 = v.br; ext_d3 = v.ext;
    end else begin
      drive2(v);
    end
    @(negedge clk);
    if (d3) begin
      chk("d3_ctl", idx, {3'b0, sf3, sd3, fd3, fe3, se3}, {3'b0, v.ctl});
      chk("d3_sel", idx, {4'b0, fwd3}, {4'b0, v.s1, v.s0});
    end else begin
      chk("d2_ctl", idx, {3'b0, sf2, sd2, fd2, fe2, se2}, {3'b0, v.ctl});
      chk("d2_sel", idx, {4'b0, fwd2}, {4'b0, v.s1, v.s0});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t bub;
    bub = mk(0,0,0,0, 0,0,0,0,0,0, 0,0,0);
    // FWD_DEPTH=2 stream: cycle-by-cycle D-stage instruction and expected outputs
    tab2[0]  = mk(1,0,0,0, 1,1,0,0,0,0, 0,0,0);          // ADD r1
    tab2[1]  = mk(1,1,3,3, 2,1,0,0,0,0, 0,0,0);          // SUB r2,r1,r3
    tab2[2]  = mk(1,1,0,3, 7,1,0,0,0,0, 0,1,0);          // AND r7,r1,r0; SUB op0 from M
    tab2[3]  = mk(0,0,0,0, 0,0,0,0,0,0, 0,2,0);          // AND op0 from W
    tab2[4]  = mk(1,0,0,1, 4,1,1,0,0,0, 0,0,0);          // LDR r4,[r0]
    tab2[5]  = mk(1,4,4,3, 5,1,0,0,0,0, 'b11010,0,0);    // ADD r5,r4,r4: load-use
    tab2[6]  = mk(1,4,4,3, 5,1,0,0,0,0, 0,0,0);          // held, stall released
    tab2[7]  = mk(0,0,0,0, 0,0,0,0,0,0, 0,2,2);          // both operands from W
    tab2[8]  = mk(1,0,0,0, 9,1,1,0,0,0, 0,0,0);          // LDR r9
    tab2[9]  = mk(1,1,9,1, 10,1,0,0,0,0, 0,0,0);         // immediate in op1 slot: no stall
    tab2[10] = mk(1,0,0,0, 15,1,0,1,0,0, 'b10100,0,0);   // PC write in D
    tab2[11] = mk(1,15,0,1, 3,1,0,0,0,0, 'b10100,0,0);   // reader of r15
    tab2[12] = mk(0,0,0,0, 0,0,0,0,0,0, 'b10100,0,0);    // r15 never forwarded
    tab2[13] = mk(0,0,0,0, 0,0,0,0,0,0, 'b00100,0,0);    // PC write in W
    tab2[14] = mk(1,0,0,0, 6,1,1,0,0,0, 0,0,0);          // LDR r6
    tab2[15] = mk(1,6,0,3, 7,1,0,0,1,0, 'b00110,0,0);    // branch beats load-use
    tab2[16] = mk(1,0,0,0, 1,1,0,0,0,0, 0,0,0);          // ADD r1
    tab2[17] = mk(1,3,1,3, 2,1,0,0,0,0, 0,0,0);          // SUB r2,r3,r1
    tab2[18] = mk(0,0,0,0, 0,0,0,0,0,1, 'b11001,0,1);    // ext_stall x3
    tab2[19] = mk(0,0,0,0, 0,0,0,0,0,1, 'b11001,0,1);
    tab2[20] = mk(0,0,0,0, 0,0,0,0,0,1, 'b11001,0,1);
    tab2[21] = mk(0,0,0,0, 0,0,0,0,0,0, 0,0,1);          // records held across stall
    tab2[22] = mk(1,0,0,0, 1,1,0,0,0,0, 0,0,0);          // ADD r1
    tab2[23] = mk(1,0,0,0, 1,1,0,0,0,0, 0,0,0);          // ADD r1 again
    tab2[24] = mk(1,0,1,3, 2,1,0,0,0,0, 0,0,0);          // consumer of r1
    tab2[25] = mk(0,0,0,0, 0,0,0,0,0,0, 0,0,1);          // youngest producer (M) wins
    tab2[26] = bub;
    // FWD_DEPTH=3 stream
    tab3[0] = mk(1,0,0,0, 4,1,1,0,0,0, 0,0,0);           // LDR r4
    tab3[1] = mk(1,4,0,1, 5,1,0,0,0,0, 'b11010,0,0);     // user: stall 1
    tab3[2] = mk(1,4,0,1, 5,1,0,0,0,0, 'b11010,0,0);     // stall 2
    tab3[3] = mk(1,4,0,1, 5,1,0,0,0,0, 0,0,0);           // released
    tab3[4] = mk(1,0,0,0, 8,1,0,0,0,0, 0,3,0);           // ALU r8; user gets sel 3
    tab3[5] = bub;
    tab3[6] = bub;
    tab3[7] = mk(1,0,8,2, 9,1,0,0,0,0, 0,0,0);           // reads r8 in op1
    tab3[8] = mk(0,0,0,0, 0,0,0,0,0,0, 0,0,3);           // ALU 3 stages ahead

    reset = 1'b0;
    drive2(bub);
    ra_d3 = '0; used_d3 = '0; valid_d3 = 1'b0; wa_d3 = '0;
    rw_d3 = 1'b0; mr_d3 = 1'b0; pcw_d3 = 1'b0; br_d3 = 1'b0; ext_d3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl2", 0, {3'b0, sf2, sd2, fd2, fe2, se2}, 8'h00);
    chk("rst_sel2", 0, {4'b0, fwd2}, 8'h00);
    chk("rst_ctl3", 0, {3'b0, sf3, sd3, fd3, fe3, se3}, 8'h00);
    reset = 1'b1;

    for (int i = 0; i < 27; i++) apply(tab2[i], 1'b0, i);
    for (int i = 0; i < 9; i++) apply(tab3[i], 1'b1, i);

    // Reset while forwarding is live: outputs clear at once, in-flight producer is forgotten.
    drive2(mk(1,0,0,0, 1,1,0,0,0,0, 0,0,0));
    @(posedge clk); #1;
    drive2(mk(1,1,0,1, 2,1,0,0,0,0, 0,0,0));
    @(posedge clk); #1;
    drive2(bub);
    @(negedge clk);
    chk("pre_rst_sel", 0, {4'b0, fwd2}, 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ctl", 0, {3'b0, sf2, sd2, fd2, fe2, se2}, 8'h00);
    chk("mid_rst_sel", 0, {4'b0, fwd2}, 8'h00);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    drive2(mk(1,1,0,1, 3,1,0,0,0,0, 0,0,0));
    @(negedge clk);
    chk("post_rst_ctl", 0, {3'b0, sf2, sd2, fd2, fe2, se2}, 8'h00);
    @(posedge clk); #1;
    drive2(bub);
    @(negedge clk);
    chk("post_rst_sel", 0, {4'b0, fwd2}, 8'h00);
    @(posedge clk); #1;
    drive2(bub);
    @(negedge clk);
    chk("post_rst_sel", 1, {4'b0, fwd2}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
